// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready handshakes on both sides.
// An optional skid entry holds the raw instruction so IN_READY can come from a flop.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [PC_W-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [PC_W-1:0] out_pc_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] imm_o,
  output logic [3:0]      alu_ctl_o,
  output logic [1:0]      op1_sel_o,
  output logic [1:0]      op2_sel_o,
  output logic [1:0]      din_sel_o,
  output logic [2:0]      trim_ctl_o,
  output logic [1:0]      mm_wr_o,
  output logic [1:0]      pc_sel_o,
  output logic            reg_wr_o,
  output logic            illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_LT = 4'd3,
                         ALU_LTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR  = 4'd8, ALU_AND = 4'd9;

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu;
    logic [1:0]      op1;
    logic [1:0]      op2;
    logic [1:0]      din;
    logic [2:0]      trim;
    logic [1:0]      mm;
    logic [1:0]      pcs;
    logic            reg_wr;
    logic            illegal;
  } dec_t;

  logic            out_valid_q, skid_valid_q;
  logic [31:0]     skid_instr_q;
  logic [PC_W-1:0] skid_pc_q, out_pc_q;
  dec_t            dec_q, dec_d;
  logic [31:0]     src_instr, imm32_d;
  logic [PC_W-1:0] src_pc;
  logic            ill_d, in_fire, out_adv;
  logic [2:0]      f3;
  logic [6:0]      f7;

  function automatic logic [3:0] alu_of(input logic [2:0] fn3, input logic alt);
    case (fn3)
      3'd0:    alu_of = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_of = ALU_SLL;
      3'd2:    alu_of = ALU_LT;
      3'd3:    alu_of = ALU_LTU;
      3'd4:    alu_of = ALU_XOR;
      3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  generate
    if (SKID) begin : g_skid
      assign in_ready_o = !skid_valid_q;
    end else begin : g_noskid
      assign in_ready_o = !out_valid_q || out_ready_i;
    end
  endgenerate

  assign in_fire   = in_valid_i && in_ready_o;
  assign out_adv   = !out_valid_q || out_ready_i;
  // A held skid entry is always older than anything on the input.
  assign src_instr = skid_valid_q ? skid_instr_q : in_instr_i;
  assign src_pc    = skid_valid_q ? skid_pc_q : in_pc_i;
  assign f3        = src_instr[14:12];
  assign f7        = src_instr[31:25];

  always_comb begin
    dec_d     = '0;
    dec_d.rs1 = src_instr[19:15];
    dec_d.rs2 = src_instr[24:20];
    dec_d.rd  = src_instr[11:7];
    imm32_d   = '0;
    ill_d     = 1'b0;
    case (src_instr[6:0])
      OPC_OP: begin
        dec_d.alu    = alu_of(f3, f7[5]);
        dec_d.reg_wr = 1'b1;
        if (f7 != 7'h00 && f7 != 7'h20) ill_d = 1'b1;
        if (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) ill_d = 1'b1;
      end
      OPC_IMM: begin
        imm32_d      = {{20{src_instr[31]}}, src_instr[31:20]};
        dec_d.alu    = alu_of(f3, f3 == 3'd5 && f7[5]);
        dec_d.op2    = 2'd1;
        dec_d.reg_wr = 1'b1;
        if (f3 == 3'd1 && f7 != 7'h00) ill_d = 1'b1;
        if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill_d = 1'b1;
      end
      OPC_LOAD: begin
        imm32_d      = {{20{src_instr[31]}}, src_instr[31:20]};
        dec_d.op2    = 2'd1;
        dec_d.din    = 2'd1;
        dec_d.trim   = f3;
        dec_d.reg_wr = 1'b1;
        if (f3 == 3'd3 || f3 >= 3'd6) ill_d = 1'b1;
      end
      OPC_STORE: begin
        imm32_d   = {{20{src_instr[31]}}, src_instr[31:25], src_instr[11:7]};
        dec_d.op2 = 2'd1;
        dec_d.mm  = f3[1:0] + 2'd1;
        if (f3 > 3'd2) ill_d = 1'b1;
      end
      OPC_LUI: begin
        imm32_d      = {src_instr[31:12], 12'h000};
        dec_d.din    = 2'd2;
        dec_d.reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        imm32_d      = {src_instr[31:12], 12'h000};
        dec_d.op1    = 2'd1;
        dec_d.op2    = 2'd1;
        dec_d.reg_wr = 1'b1;
      end
      OPC_JAL: begin
        imm32_d      = {{11{src_instr[31]}}, src_instr[31], src_instr[19:12],
                        src_instr[20], src_instr[30:21], 1'b0};
        dec_d.pcs    = 2'd2;
        dec_d.din    = 2'd3;
        dec_d.reg_wr = 1'b1;
      end
      OPC_JALR: begin
        imm32_d      = {{20{src_instr[31]}}, src_instr[31:20]};
        dec_d.pcs    = 2'd3;
        dec_d.op2    = 2'd1;
        dec_d.din    = 2'd3;
        dec_d.reg_wr = 1'b1;
        if (f3 != 3'd0) ill_d = 1'b1;
      end
      OPC_BRANCH: begin
        imm32_d    = {{19{src_instr[31]}}, src_instr[31], src_instr[7],
                      src_instr[30:25], src_instr[11:8], 1'b0};
        dec_d.pcs  = 2'd1;
        dec_d.trim = f3;
        case (f3[2:1])
          2'b00:   dec_d.alu = ALU_SUB;
          2'b10:   dec_d.alu = ALU_LT;
          2'b11:   dec_d.alu = ALU_LTU;
          default: ill_d = 1'b1;
        endcase
      end
      default: ill_d = 1'b1;
    endcase
    if (src_instr[1:0] != 2'b11) ill_d = 1'b1;
    dec_d.imm = XLEN'($signed(imm32_d));
    // Illegal bundles carry no side effects: every control select is cleared.
    if (ill_d) begin
      dec_d.alu    = '0;
      dec_d.op1    = '0;
      dec_d.op2    = '0;
      dec_d.din    = '0;
      dec_d.trim   = '0;
      dec_d.mm     = '0;
      dec_d.pcs    = '0;
      dec_d.reg_wr = 1'b0;
    end
    if (dec_d.rd == 5'd0) dec_d.reg_wr = 1'b0;
    dec_d.illegal = ill_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      out_pc_q     <= '0;
      dec_q        <= '0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_adv) begin
      out_valid_q  <= skid_valid_q || in_fire;
      skid_valid_q <= 1'b0;
      if (skid_valid_q || in_fire) begin
        out_pc_q <= src_pc;
        dec_q    <= dec_d;
      end
    end else if (SKID && in_fire) begin
      skid_valid_q <= 1'b1;
      skid_instr_q <= in_instr_i;
      skid_pc_q    <= in_pc_i;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_pc_o    = out_pc_q;
  assign rs1_o       = dec_q.rs1;
  assign rs2_o       = dec_q.rs2;
  assign rd_o        = dec_q.rd;
  assign imm_o       = dec_q.imm;
  assign alu_ctl_o   = dec_q.alu;
  assign op1_sel_o   = dec_q.op1;
  assign op2_sel_o   = dec_q.op2;
  assign din_sel_o   = dec_q.din;
  assign trim_ctl_o  = dec_q.trim;
  assign mm_wr_o     = dec_q.mm;
  assign pc_sel_o    = dec_q.pcs;
  assign reg_wr_o    = dec_q.reg_wr;
  assign illegal_o   = dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, skid stall/drain, flush and async reset.
module tb_decode_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        in_ready, out_valid, reg_wr, illegal;
  logic [31:0] out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_ctl;
  logic [1:0]  op1_sel, op2_sel, din_sel, mm_wr, pc_sel;
  logic [2:0]  trim_ctl;

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage #(.XLEN(32), .PC_W(32), .SKID(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_instr_i(in_instr), .in_pc_i(in_pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .imm_o(imm), .alu_ctl_o(alu_ctl),
    .op1_sel_o(op1_sel), .op2_sel_o(op2_sel), .din_sel_o(din_sel), .trim_ctl_o(trim_ctl),
    .mm_wr_o(mm_wr), .pc_sel_o(pc_sel), .reg_wr_o(reg_wr), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [1:0]  op1, op2, din;
    logic [2:0]  trim;
    logic [1:0]  mm, pcs;
    logic        rw, ill;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[15];
  logic [4:0] got_rd[$];

  initial begin
    //            instr         imm           alu   op1   op2   din   trim  mm    pcs   rw    ill   rd
    vecs[0]  = '{32'h002081B3, 32'h00000000, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd3};
    vecs[1]  = '{32'hFE20AE23, 32'hFFFFFFFC, 4'd0, 2'd0, 2'd1, 2'd0, 3'd0, 2'd3, 2'd0, 1'b0, 1'b0, 5'd28};
    vecs[2]  = '{32'hFE000CE3, 32'hFFFFFFF8, 4'd1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd1, 1'b0, 1'b0, 5'd25};
    vecs[3]  = '{32'h00100013, 32'h00000001, 4'd0, 2'd0, 2'd1, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0};
    vecs[4]  = '{32'h123452B7, 32'h12345000, 4'd0, 2'd0, 2'd0, 2'd2, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd5};
    vecs[5]  = '{32'h00001317, 32'h00001000, 4'd0, 2'd1, 2'd1, 2'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd6};
    vecs[6]  = '{32'h008000EF, 32'h00000008, 4'd0, 2'd0, 2'd0, 2'd3, 3'd0, 2'd0, 2'd2, 1'b1, 1'b0, 5'd1};
    vecs[7]  = '{32'h00008067, 32'h00000000, 4'd0, 2'd0, 2'd1, 2'd3, 3'd0, 2'd0, 2'd3, 1'b0, 1'b0, 5'd0};
    vecs[8]  = '{32'h00412283, 32'h00000004, 4'd0, 2'd0, 2'd1, 2'd1, 3'd2, 2'd0, 2'd0, 1'b1, 1'b0, 5'd5};
    vecs[9]  = '{32'h4030D093, 32'h00000403, 4'd7, 2'd0, 2'd1, 2'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd1};
    vecs[10] = '{32'h0020C463, 32'h00000008, 4'd3, 2'd0, 2'd0, 2'd0, 3'd4, 2'd0, 2'd1, 1'b0, 1'b0, 5'd8};
    vecs[11] = '{32'h00013283, 32'h00000000, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd5};
    vecs[12] = '{32'hFFFFFFFF, 32'h00000000, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd31};
    vecs[13] = '{32'h802081B3, 32'h00000000, 4'd0, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd3};
    vecs[14] = '{32'h402081B3, 32'h00000000, 4'd1, 2'd0, 2'd0, 2'd0, 3'd0, 2'd0, 2'd0, 1'b1, 1'b0, 5'd3};

    // Reset state while RST is held
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.imm", imm, 32'd0);
    check_eq("rst.rd", 32'(rd), 32'd0);
    check_eq("rst.reg_wr", 32'(reg_wr), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rst.in_ready", 32'(in_ready), 32'd1);

    // Decode table, one instruction at a time, 1-cycle latency
    for (int i = 0; i < 15; i++) begin
      in_instr = vecs[i].ins;
      in_pc    = 32'h100 + 32'(i) * 4;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      $display("vec %0d instr=%08h imm=%08h alu=%0d rd=%0d reg_wr=%0b illegal=%0b",
               i, vecs[i].ins, imm, alu_ctl, rd, reg_wr, illegal);
      check_eq($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'd1);
      check_eq($sformatf("v%0d.pc", i), out_pc, 32'h100 + 32'(i) * 4);
      check_eq($sformatf("v%0d.imm", i), imm, vecs[i].imm);
      check_eq($sformatf("v%0d.alu", i), 32'(alu_ctl), 32'(vecs[i].alu));
      check_eq($sformatf("v%0d.op1", i), 32'(op1_sel), 32'(vecs[i].op1));
      check_eq($sformatf("v%0d.op2", i), 32'(op2_sel), 32'(vecs[i].op2));
      check_eq($sformatf("v%0d.din", i), 32'(din_sel), 32'(vecs[i].din));
      check_eq($sformatf("v%0d.trim", i), 32'(trim_ctl), 32'(vecs[i].trim));
      check_eq($sformatf("v%0d.mm_wr", i), 32'(mm_wr), 32'(vecs[i].mm));
      check_eq($sformatf("v%0d.pc_sel", i), 32'(pc_sel), 32'(vecs[i].pcs));
      check_eq($sformatf("v%0d.reg_wr", i), 32'(reg_wr), 32'(vecs[i].rw));
      check_eq($sformatf("v%0d.illegal", i), 32'(illegal), 32'(vecs[i].ill));
      check_eq($sformatf("v%0d.rd", i), 32'(rd), 32'(vecs[i].rd));
    end
    @(posedge clk); #1;
    check_eq("drain.out_valid", 32'(out_valid), 32'd0);

    // Skid: stream addi x1..x4 with OUT_READY low for 3 cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    @(posedge clk); #1;
    check_eq("skid.ready_after1", 32'(in_ready), 32'd1);
    in_instr = 32'h00100113;
    @(posedge clk); #1;
    check_eq("skid.ready_after2", 32'(in_ready), 32'd0);
    check_eq("skid.hold_rd", 32'(rd), 32'd1);
    in_instr = 32'h00100193;
    @(posedge clk); #1;
    check_eq("skid.stall_ready", 32'(in_ready), 32'd0);
    check_eq("skid.stall_rd", 32'(rd), 32'd1);
    check_eq("skid.stall_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    begin
      int idx = 2;
      for (int cyc = 0; cyc < 20 && got_rd.size() < 4; cyc++) begin
        logic acc;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) got_rd.push_back(rd);
        @(posedge clk); #1;
        if (acc) begin
          idx++;
          if (idx == 3) in_instr = 32'h00100213;
          else in_valid = 1'b0;
        end
      end
    end
    check_eq("skid.count", 32'(got_rd.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_rd.size()) begin
        $display("skid out %0d rd=%0d", k, got_rd[k]);
        check_eq($sformatf("skid.order%0d", k), 32'(got_rd[k]), 32'(k + 1));
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Flush with two entries held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h002081B3;
    @(posedge clk); #1;
    in_instr = 32'h00100093;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("flush.full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    $display("flush held: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    check_eq("flush.out_valid", 32'(out_valid), 32'd0);
    check_eq("flush.in_ready", 32'(in_ready), 32'd1);

    // Flush drops an input accepted the same cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    flush     = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush.drop_in", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("flush.no_ghost", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h123452B7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("arst.pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("async reset: out_valid=%0b imm=%08h", out_valid, imm);
    check_eq("arst.out_valid", 32'(out_valid), 32'd0);
    check_eq("arst.imm", imm, 32'd0);
    check_eq("arst.rd", 32'(rd), 32'd0);
    check_eq("arst.din", 32'(din_sel), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("arst.in_ready", 32'(in_ready), 32'd1);
    check_eq("arst.idle", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
